// File: rtl/mem_access_unit.sv
// M-stage load/store initiator: legality checks, byte-lane steering, req/ack bus handshake with timeout.
// Stall is asserted from the issuing IDLE cycle through REQ; completion is a one-cycle done pulse.
module mem_access_unit #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000,
  parameter int          TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_wr,
  input  logic [2:0]  op_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_err,
  output logic [31:0] exc_pc,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic        we_q, err_q;
  logic [31:0] addr_q, wdata_q, pc_q, rdata_q;
  logic [3:0]  be_q;
  logic [1:0]  lane_q;
  logic [2:0]  type_q;

  logic        illegal, misaligned, out_of_range, fault, issue, fault_pulse;
  logic [3:0]  be_n;
  logic [31:0] wdata_n, load_ext;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    illegal      = (op_type > 3'd4) || (op_wr && (op_type == 3'd2 || op_type == 3'd4));
    misaligned   = ((op_type == 3'd0) && (addr[1:0] != 2'b00)) ||
                   ((op_type == 3'd1 || op_type == 3'd2) && addr[0]);
    out_of_range = (addr >= ADDR_LIMIT);
    fault        = illegal || misaligned || out_of_range;
    issue        = !reset && (state == S_IDLE) && op_valid && !fault;
    fault_pulse  = !reset && (state == S_IDLE) && op_valid && fault;
  end

  always_comb begin
    be_n    = 4'b0001 << addr[1:0];
    wdata_n = {4{wdata[7:0]}};
    case (op_type)
      3'd0: begin
        be_n    = 4'b1111;
        wdata_n = wdata;
      end
      3'd1, 3'd2: begin
        be_n    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Extraction uses the latched lane/type so the pipeline may change addr while stalled.
  always_comb begin
    half_sel = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (lane_q)
      2'd0:    byte_sel = bus_rdata[7:0];
      2'd1:    byte_sel = bus_rdata[15:8];
      2'd2:    byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
    case (type_q)
      3'd1:    load_ext = {{16{half_sel[15]}}, half_sel};
      3'd2:    load_ext = {16'h0000, half_sel};
      3'd3:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'd4:    load_ext = {24'h000000, byte_sel};
      default: load_ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 8'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      pc_q    <= 32'd0;
      rdata_q <= 32'd0;
      be_q    <= 4'd0;
      lane_q  <= 2'd0;
      type_q  <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue) begin
            we_q    <= op_wr;
            addr_q  <= {addr[31:2], 2'b00};
            be_q    <= be_n;
            wdata_q <= wdata_n;
            lane_q  <= addr[1:0];
            type_q  <= op_type;
            pc_q    <= pc;
            err_q   <= 1'b0;
            cnt     <= 8'd0;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          // An ack on the final counted cycle wins over the timeout.
          if (bus_ack) begin
            rdata_q <= we_q ? 32'd0 : load_ext;
            err_q   <= 1'b0;
            state   <= S_DONE;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus_req   = (state == S_REQ);
    bus_we    = we_q;
    bus_addr  = addr_q;
    bus_be    = be_q;
    bus_wdata = wdata_q;
    stall     = issue || (state == S_REQ);
    done      = (state == S_DONE);
    rdata     = done ? rdata_q : 32'd0;
    bus_err   = done && err_q;
    exc_adel  = fault_pulse && !op_wr;
    exc_ades  = fault_pulse && op_wr;
    exc_pc    = fault_pulse ? pc : (bus_err ? pc_q : 32'd0);
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a byte-level reference model.
module tb_mem_access_unit;

  logic        clk, reset;
  logic        op_valid, op_wr;
  logic [2:0]  op_type;
  logic [31:0] addr, wdata, pc;
  logic        stall, done, exc_adel, exc_ades, bus_err;
  logic [31:0] rdata, exc_pc;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int checks = 0;
  int passed = 0;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_wr(op_wr), .op_type(op_type),
    .addr(addr), .wdata(wdata), .pc(pc), .stall(stall), .done(done), .rdata(rdata),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .bus_err(bus_err), .exc_pc(exc_pc),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] ty);
    if (ty == 3'd0) return 4;
    if (ty <= 3'd2) return 2;
    return 1;
  endfunction

  function automatic bit m_fault(input logic wr, input logic [2:0] ty, input logic [31:0] a);
    if (ty > 3'd4) return 1'b1;
    if (wr && (ty == 3'd2 || ty == 3'd4)) return 1'b1;
    if (a >= 32'h0000_1000) return 1'b1;
    return (a % m_size(ty)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] ty, input logic [31:0] a);
    int nb;
    int v;
    nb = m_size(ty);
    v = ((1 << nb) - 1) << (a % 4);
    return 4'(v);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] ty, input logic [31:0] wd);
    logic [31:0] h, b;
    h = {16'h0, wd[15:0]};
    b = {24'h0, wd[7:0]};
    if (m_size(ty) == 4) return wd;
    if (m_size(ty) == 2) return h * 32'h0001_0001;
    return b * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] ty, input logic [31:0] a, input logic [31:0] w);
    int nb;
    logic [31:0] mask, v;
    if (ty == 3'd0) return w;
    nb = m_size(ty);
    mask = (32'h1 << (8 * nb)) - 32'h1;
    v = (w >> (8 * (a % 4))) & mask;
    if ((ty == 3'd1 || ty == 3'd3) && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- stimulus driver (observes, does not judge) ----------------
  task automatic drive_op(input logic wr, input logic [2:0] ty, input logic [31:0] a, wd, p,
                          input int wait_n, input logic [31:0] word,
                          output int nreq, output logic [3:0] be0, output logic [31:0] addr0,
                          output logic [31:0] wdata0, output logic we0, output bit stable,
                          output bit stall_ok, output logic [31:0] rd, output logic err,
                          output logic [31:0] epc, output bit got_done, output bit idle_ok);
    @(negedge clk);
    op_valid = 1'b1; op_wr = wr; op_type = ty; addr = a; wdata = wd; pc = p;
    bus_ack = 1'b0; bus_rdata = word;
    #1;
    stall_ok = (stall === 1'b1);
    nreq = 0; stable = 1'b1; got_done = 1'b0;
    be0 = 4'h0; addr0 = 32'h0; wdata0 = 32'h0; we0 = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) begin
        got_done = 1'b1;
        break;
      end
      if (bus_req === 1'b1) begin
        nreq++;
        if (nreq == 1) begin
          be0 = bus_be; addr0 = bus_addr; wdata0 = bus_wdata; we0 = bus_we;
        end else if (bus_be !== be0 || bus_addr !== addr0 || bus_wdata !== wdata0 || bus_we !== we0) begin
          stable = 1'b0;
        end
        if (stall !== 1'b1) stall_ok = 1'b0;
      end else begin
        stable = 1'b0;
      end
      bus_ack = (wait_n >= 0) && (nreq == wait_n + 1);
      @(posedge clk); #1;
    end
    rd = rdata; err = bus_err; epc = exc_pc;
    if (stall !== 1'b0 || bus_req !== 1'b0) stall_ok = 1'b0;
    bus_ack = 1'b0; op_valid = 1'b0;
    @(posedge clk); #1;
    idle_ok = (done === 1'b0) && (stall === 1'b0) && (bus_req === 1'b0) && (bus_err === 1'b0);
  endtask

  // ---------------- feature tests ----------------
  task automatic test_reset();
    reset = 1'b1; op_valid = 1'b0; op_wr = 1'b0; op_type = 3'd0; addr = 32'h0;
    wdata = 32'h0; pc = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({stall, done, exc_adel, exc_ades, bus_err, bus_req, bus_we} !== 7'b0)
      $display("FAIL reset_ctrl got %b want 0", {stall, done, exc_adel, exc_ades, bus_err, bus_req, bus_we}); else passed++;
    checks++; if ({rdata, exc_pc, bus_addr, bus_wdata, bus_be} !== 132'b0)
      $display("FAIL reset_data got rdata=%h exc_pc=%h addr=%h wdata=%h be=%h want 0", rdata, exc_pc, bus_addr, bus_wdata, bus_be); else passed++;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_aligned_lw();
    int n; logic [3:0] be; logic [31:0] ba, bw, rd, epc; logic we, err; bit st, sok, gd, iok;
    drive_op(1'b0, 3'd0, 32'h10, 32'h0, 32'h400, 3, 32'hDEADBEEF, n, be, ba, bw, we, st, sok, rd, err, epc, gd, iok);
    checks++; if (n != 4) $display("FAIL lw_req_cycles got %0d want 4", n); else passed++;
    checks++; if (be !== 4'hF || ba !== 32'h10 || we !== 1'b0) $display("FAIL lw_bus got be=%h addr=%h we=%b want f/10/0", be, ba, we); else passed++;
    checks++; if (!(st && sok && gd && iok)) $display("FAIL lw_handshake got stable=%0d stall_ok=%0d done=%0d idle=%0d want 1111", st, sok, gd, iok); else passed++;
    checks++; if (rd !== 32'hDEADBEEF || err !== 1'b0) $display("FAIL lw_rdata got %h err=%b want deadbeef err=0", rd, err); else passed++;
  endtask

  task automatic test_sb_lb();
    int n; logic [3:0] be; logic [31:0] ba, bw, rd, epc; logic we, err; bit st, sok, gd, iok;
    drive_op(1'b1, 3'd3, 32'h23, 32'h000000A5, 32'h500, 1, 32'h0, n, be, ba, bw, we, st, sok, rd, err, epc, gd, iok);
    checks++; if (be !== 4'b1000 || bw !== 32'hA5A5A5A5 || we !== 1'b1 || ba !== 32'h20)
      $display("FAIL sb_bus got be=%b wdata=%h we=%b addr=%h want 1000/a5a5a5a5/1/20", be, bw, we, ba); else passed++;
    checks++; if (rd !== 32'h0 || !gd || !iok) $display("FAIL sb_done got rdata=%h done=%0d idle=%0d want 0/1/1", rd, gd, iok); else passed++;
    drive_op(1'b0, 3'd3, 32'h23, 32'h0, 32'h504, 0, 32'hA5000000, n, be, ba, bw, we, st, sok, rd, err, epc, gd, iok);
    checks++; if (rd !== 32'hFFFFFFA5 || n != 1) $display("FAIL lb_rdata got %h cycles=%0d want ffffffa5/1", rd, n); else passed++;
    drive_op(1'b0, 3'd4, 32'h23, 32'h0, 32'h508, 2, 32'hA5000000, n, be, ba, bw, we, st, sok, rd, err, epc, gd, iok);
    checks++; if (rd !== 32'h000000A5) $display("FAIL lbu_rdata got %h want 000000a5", rd); else passed++;
  endtask

  task automatic test_halfword();
    int n; logic [3:0] be; logic [31:0] ba, bw, rd, epc; logic we, err; bit st, sok, gd, iok;
    drive_op(1'b0, 3'd1, 32'h2, 32'h0, 32'h600, 0, 32'h8001_7FFE, n, be, ba, bw, we, st, sok, rd, err, epc, gd, iok);
    checks++; if (rd !== 32'hFFFF8001 || be !== 4'b1100) $display("FAIL lh2 got %h be=%b want ffff8001/1100", rd, be); else passed++;
    drive_op(1'b0, 3'd2, 32'h2, 32'h0, 32'h604, 1, 32'h8001_7FFE, n, be, ba, bw, we, st, sok, rd, err, epc, gd, iok);
    checks++; if (rd !== 32'h00008001) $display("FAIL lhu2 got %h want 00008001", rd); else passed++;
    drive_op(1'b0, 3'd1, 32'h0, 32'h0, 32'h608, 0, 32'h8001_7FFE, n, be, ba, bw, we, st, sok, rd, err, epc, gd, iok);
    checks++; if (rd !== 32'h00007FFE || be !== 4'b0011) $display("FAIL lh0 got %h be=%b want 00007ffe/0011", rd, be); else passed++;
  endtask

  task automatic test_faults();
    logic        fwr[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0]  fty[9] = '{3'd0, 3'd1, 3'd5, 3'd5, 3'd0, 3'd0, 3'd2, 3'd7, 3'd1};
    logic [31:0] fad[9] = '{32'h6, 32'h1, 32'h40, 32'h40, 32'h1000, 32'h1000, 32'h8, 32'h0, 32'h3};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      op_valid = 1'b1; op_wr = fwr[i]; op_type = fty[i]; addr = fad[i]; pc = 32'h700 + 32'(i * 4);
      #1;
      checks++; if (exc_adel !== !fwr[i] || exc_ades !== fwr[i] || exc_pc !== 32'h700 + 32'(i * 4) || stall !== 1'b0)
        $display("FAIL fault%0d got adel=%b ades=%b exc_pc=%h stall=%b want %b/%b/%h/0", i, exc_adel, exc_ades, exc_pc, stall, !fwr[i], fwr[i], 32'h700 + 32'(i * 4)); else passed++;
      @(posedge clk); #1;
      op_valid = 1'b0;
      #1;
      checks++; if (bus_req !== 1'b0 || exc_adel !== 1'b0 || exc_ades !== 1'b0 || done !== 1'b0)
        $display("FAIL fault%0d_after got req=%b adel=%b ades=%b done=%b want 0", i, bus_req, exc_adel, exc_ades, done); else passed++;
    end
  endtask

  task automatic test_timeout();
    int n; logic [3:0] be; logic [31:0] ba, bw, rd, epc; logic we, err; bit st, sok, gd, iok;
    drive_op(1'b0, 3'd0, 32'h44, 32'h0, 32'h800, -1, 32'h12345678, n, be, ba, bw, we, st, sok, rd, err, epc, gd, iok);
    checks++; if (n != 16) $display("FAIL to_req_cycles got %0d want 16", n); else passed++;
    checks++; if (!gd || err !== 1'b1 || rd !== 32'h0 || epc !== 32'h800)
      $display("FAIL to_done got done=%0d err=%b rdata=%h exc_pc=%h want 1/1/0/800", gd, err, rd, epc); else passed++;
    checks++; if (!iok) $display("FAIL to_idle got busy want idle"); else passed++;
  endtask

  task automatic test_reset_mid();
    int n; logic [3:0] be; logic [31:0] ba, bw, rd, epc; logic we, err; bit st, sok, gd, iok;
    bit quiet;
    @(negedge clk);
    op_valid = 1'b1; op_wr = 1'b0; op_type = 3'd0; addr = 32'h80; pc = 32'h900; bus_ack = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++; if (bus_req !== 1'b0 || stall !== 1'b0 || done !== 1'b0)
      $display("FAIL rst_mid got req=%b stall=%b done=%b want 0", bus_req, stall, done); else passed++;
    op_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    quiet = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (bus_req !== 1'b0 || done !== 1'b0 || stall !== 1'b0) quiet = 1'b0;
    end
    bus_ack = 1'b0;
    checks++; if (!quiet) $display("FAIL rst_stray_ack got activity want none"); else passed++;
    drive_op(1'b0, 3'd0, 32'h84, 32'h0, 32'h904, 2, 32'h0BADC0DE, n, be, ba, bw, we, st, sok, rd, err, epc, gd, iok);
    checks++; if (rd !== 32'h0BADC0DE || n != 3 || !gd || !iok)
      $display("FAIL rst_next got rdata=%h cycles=%0d want 0badc0de/3", rd, n); else passed++;
  endtask

  task automatic test_random();
    int n, w; logic [3:0] be; logic [31:0] ba, bw, rd, epc, a, wd, word, p; logic we, err, wr; logic [2:0] ty;
    bit st, sok, gd, iok;
    for (int i = 0; i < 150; i++) begin
      wr = 1'($urandom_range(0, 1));
      ty = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 32'h1010));
      wd = $urandom; word = $urandom; p = $urandom;
      w  = $urandom_range(0, 5);
      if (m_fault(wr, ty, a)) begin
        @(negedge clk);
        op_valid = 1'b1; op_wr = wr; op_type = ty; addr = a; pc = p;
        #1;
        checks++; if (exc_adel !== !wr || exc_ades !== wr || exc_pc !== p || stall !== 1'b0)
          $display("FAIL rnd_fault%0d got adel=%b ades=%b pc=%h stall=%b", i, exc_adel, exc_ades, exc_pc, stall); else passed++;
        @(posedge clk); #1;
        op_valid = 1'b0;
        checks++; if (bus_req !== 1'b0) $display("FAIL rnd_fault_req%0d got %b want 0", i, bus_req); else passed++;
      end else begin
        drive_op(wr, ty, a, wd, p, w, word, n, be, ba, bw, we, st, sok, rd, err, epc, gd, iok);
        checks++; if (be !== m_be(ty, a) || ba !== (a & ~32'h3) || we !== wr || (wr && bw !== m_wdata(ty, wd)))
          $display("FAIL rnd_bus%0d got be=%b addr=%h we=%b wdata=%h want %b/%h/%b/%h", i, be, ba, we, bw, m_be(ty, a), a & ~32'h3, wr, m_wdata(ty, wd)); else passed++;
        checks++; if (rd !== (wr ? 32'h0 : m_load(ty, a, word)) || n != w + 1 || err !== 1'b0 || !(st && sok && gd && iok))
          $display("FAIL rnd_result%0d got rdata=%h cycles=%0d err=%b want %h/%0d/0", i, rd, n, err, wr ? 32'h0 : m_load(ty, a, word), w + 1); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_aligned_lw();
    test_sb_lb();
    test_halfword();
    test_faults();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
